// File: rtl/aes_pkg.sv
// Shared AES definitions: key-schedule FSM states, round constants and word helpers.
// Used by the key expansion block and its round-key store.
package aes_pkg;

    localparam int AES_KEY_W  = 128;
    localparam int AES_BYTE_W = 8;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_REQ,
        ST_GAP,
        ST_MIX,
        ST_DONE
    } state_t;

    // Entry 0 is never used; round r uses RCON[r].
    localparam logic [7:0] RCON [0:10] = '{
        8'h00, 8'h01, 8'h02, 8'h04, 8'h08, 8'h10,
        8'h20, 8'h40, 8'h80, 8'h1b, 8'h36
    };

    function automatic logic [31:0] rot_word(input logic [31:0] w);
        return {w[23:0], w[31:24]};
    endfunction

endpackage

// File: rtl/aes_rk_store.sv
// Round-key register file: one write port and one registered read port.
// An out-of-range read index returns zero; a same-cycle read returns the pre-write contents.
module aes_rk_store
    import aes_pkg::*;
#(
    parameter int DEPTH  = 11,
    parameter int ADDR_W = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 i_we,
    input  logic [ADDR_W-1:0]    i_waddr,
    input  logic [AES_KEY_W-1:0] i_wdata,
    input  logic [ADDR_W-1:0]    i_raddr,
    output logic [AES_KEY_W-1:0] o_rdata
);

    logic [AES_KEY_W-1:0] r_mem [0:DEPTH-1];
    logic [AES_KEY_W-1:0] r_rdata;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int n = 0; n < DEPTH; n++) begin
                r_mem[n] <= '0;
            end
            r_rdata <= '0;
        end else begin
            if (i_we) begin
                r_mem[i_waddr] <= i_wdata;
            end
            r_rdata <= (int'(i_raddr) < DEPTH) ? r_mem[i_raddr] : '0;
        end
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/aes_key_expand.sv
// AES-128 key schedule: expands the cipher key into NR+1 round keys, using the
// shared S-box memory (req/ack handshake) for SubWord, one byte per lookup.
module aes_key_expand
    import aes_pkg::*;
#(
    parameter int NR          = 10,
    parameter int ACK_TIMEOUT = 64
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [AES_KEY_W-1:0]  key,
    output logic [AES_BYTE_W-1:0] sbox_addr,
    output logic                  sbox_req,
    input  logic                  sbox_ack,
    input  logic [AES_BYTE_W-1:0] sbox_data,
    input  logic [3:0]            rk_sel,
    output logic [AES_KEY_W-1:0]  rk_out,
    output logic [NR:0]           rk_valid,
    output logic                  busy,
    output logic                  done,
    output logic                  err
);

    localparam int TMO_W = (ACK_TIMEOUT < 2) ? 1 : $clog2(ACK_TIMEOUT + 1);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(ACK_TIMEOUT - 1);

    state_t               r_state;
    state_t               w_nextState;
    logic [3:0]           r_round;
    logic [1:0]           r_byte;
    logic [TMO_W-1:0]     r_tmo;
    logic [AES_KEY_W-1:0] r_key;
    logic [31:0]          r_sub;
    logic [NR:0]          r_valid;
    logic                 r_err;

    logic                 w_ackHit;
    logic                 w_tmoHit;
    logic [31:0]          w_rot;
    logic [31:0]          w_t;
    logic [31:0]          w_w0;
    logic [31:0]          w_w1;
    logic [31:0]          w_w2;
    logic [31:0]          w_w3;
    logic [AES_KEY_W-1:0] w_next;
    logic                 w_we;
    logic [3:0]           w_waddr;
    logic [AES_KEY_W-1:0] w_wdata;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    always_comb begin
        w_nextState = r_state;
        w_ackHit    = 1'b0;
        w_tmoHit    = 1'b0;
        case (r_state)
            ST_IDLE: if (start) w_nextState = ST_LOAD;
            ST_LOAD: w_nextState = ST_REQ;
            ST_REQ: begin
                if (sbox_ack) begin
                    w_ackHit    = 1'b1;
                    w_nextState = ST_GAP;
                end else if ((ACK_TIMEOUT != 0) && (r_tmo == TMO_LAST)) begin
                    w_tmoHit    = 1'b1;
                    w_nextState = ST_IDLE;
                end
            end
            ST_GAP:  w_nextState = (r_byte == 2'd3) ? ST_MIX : ST_REQ;
            ST_MIX:  w_nextState = (r_round == 4'(NR)) ? ST_DONE : ST_REQ;
            ST_DONE: w_nextState = ST_IDLE;
            default: w_nextState = ST_IDLE;
        endcase
    end

    // Lookup byte i of RotWord(w3), most significant byte first.
    assign w_rot = rot_word(r_key[31:0]);
    always_comb begin
        sbox_addr = w_rot[31:24];
        case (r_byte)
            2'd0:    sbox_addr = w_rot[31:24];
            2'd1:    sbox_addr = w_rot[23:16];
            2'd2:    sbox_addr = w_rot[15:8];
            default: sbox_addr = w_rot[7:0];
        endcase
    end

    assign w_t    = r_sub ^ {RCON[r_round], 24'h0};
    assign w_w0   = r_key[127:96] ^ w_t;
    assign w_w1   = r_key[95:64]  ^ w_w0;
    assign w_w2   = r_key[63:32]  ^ w_w1;
    assign w_w3   = r_key[31:0]   ^ w_w2;
    assign w_next = {w_w0, w_w1, w_w2, w_w3};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_round <= '0;
            r_byte  <= '0;
            r_tmo   <= '0;
            r_key   <= '0;
            r_sub   <= '0;
            r_valid <= '0;
            r_err   <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_key   <= key;
                        r_valid <= '0;
                        r_err   <= 1'b0;
                    end
                end
                ST_LOAD: begin
                    r_valid[0] <= 1'b1;
                    r_round    <= 4'd1;
                    r_byte     <= 2'd0;
                    r_tmo      <= '0;
                end
                ST_REQ: begin
                    if (w_ackHit) begin
                        r_sub <= {r_sub[23:0], sbox_data};
                        r_tmo <= '0;
                    end else begin
                        r_tmo <= r_tmo + 1'b1;
                    end
                    if (w_tmoHit) begin
                        r_err <= 1'b1;
                    end
                end
                ST_GAP: begin
                    r_byte <= r_byte + 2'd1;
                    r_tmo  <= '0;
                end
                ST_MIX: begin
                    r_key            <= w_next;
                    r_valid[r_round] <= 1'b1;
                    if (r_round != 4'(NR)) begin
                        r_round <= r_round + 4'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    // rk0 is the raw key, written during LOAD; later rounds come from MIX.
    assign w_we    = (r_state == ST_LOAD) || (r_state == ST_MIX);
    assign w_waddr = (r_state == ST_LOAD) ? 4'd0 : r_round;
    assign w_wdata = (r_state == ST_LOAD) ? r_key : w_next;

    aes_rk_store #(
        .DEPTH  (NR + 1),
        .ADDR_W (4)
    ) u_store (
        .clk     (clk),
        .rst     (rst),
        .i_we    (w_we),
        .i_waddr (w_waddr),
        .i_wdata (w_wdata),
        .i_raddr (rk_sel),
        .o_rdata (rk_out)
    );

    assign sbox_req = (r_state == ST_REQ);
    assign busy     = (r_state != ST_IDLE);
    assign done     = (r_state == ST_DONE);
    assign err      = r_err;
    assign rk_valid = r_valid;

endmodule

// File: tb/tb_aes_key_expand.sv
// Self-checking bench for aes_key_expand: S-box memory responder, FIPS-197 style
// reference key schedule, table-driven known vectors plus randomized keys and delays.
module tb_aes_key_expand;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [127:0] key;
    logic [7:0]   sbox_addr;
    logic         sbox_req;
    logic         sbox_ack;
    logic [7:0]   sbox_data;
    logic [3:0]   rk_sel;
    logic [127:0] rk_out;
    logic [10:0]  rk_valid;
    logic         busy;
    logic         done;
    logic         err;

    aes_key_expand #(.NR(10), .ACK_TIMEOUT(64)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .key       (key),
        .sbox_addr (sbox_addr),
        .sbox_req  (sbox_req),
        .sbox_ack  (sbox_ack),
        .sbox_data (sbox_data),
        .rk_sel    (rk_sel),
        .rk_out    (rk_out),
        .rk_valid  (rk_valid),
        .busy      (busy),
        .done      (done),
        .err       (err)
    );

    always #5 clk = ~clk;

    int           nCompared = 0;
    int           nFailed   = 0;
    logic [7:0]   sboxTab [0:255];
    logic [127:0] refRk [0:10];
    logic [127:0] lastRk0 = '0;
    bit           ackEnable = 1'b1;
    int           minDelay = 1;
    int           maxDelay = 1;
    int           addrViol = 0;
    int           gapViol  = 0;
    logic         monPrevReq = 1'b0;
    logic [7:0]   monPrevAddr = 8'h00;

    localparam logic [127:0] KEY_A1   = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] KEY_ZERO = 128'h0;

    typedef struct {
        string        name;
        logic [127:0] key;
        int           minD;
        int           maxD;
        logic [127:0] rk1;
        logic [127:0] rk10;
    } vec_t;

    // GF(2^8) multiply with the AES polynomial, used to build the S-box from first principles
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] aa;
        logic [7:0] bb;
        p = 8'h00; aa = a; bb = b;
        for (int k = 0; k < 8; k++) begin
            if (bb[0]) p = p ^ aa;
            aa = aa[7] ? ({aa[6:0], 1'b0} ^ 8'h1b) : {aa[6:0], 1'b0};
            bb = {1'b0, bb[7:1]};
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] x, input int n);
        logic [15:0] d;
        d = {x, x} << n;
        return d[15:8];
    endfunction

    // S-box = affine transform of the multiplicative inverse
    task automatic buildSbox();
        logic [7:0] inv;
        for (int x = 0; x < 256; x++) begin
            inv = 8'h00;
            for (int y = 1; y < 256; y++) begin
                if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            end
            sboxTab[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
        end
    endtask

    // Reference schedule as the classic 44-word recurrence
    task automatic computeRef(input logic [127:0] k);
        logic [31:0] w [0:43];
        logic [31:0] tmp;
        logic [7:0]  rc;
        rc = 8'h01;
        for (int i = 0; i < 4; i++) w[i] = k[127 - 32*i -: 32];
        for (int i = 4; i < 44; i++) begin
            tmp = w[i-1];
            if (i % 4 == 0) begin
                tmp = {tmp[23:0], tmp[31:24]};
                tmp = {sboxTab[tmp[31:24]], sboxTab[tmp[23:16]], sboxTab[tmp[15:8]], sboxTab[tmp[7:0]]};
                tmp = tmp ^ {rc, 24'h0};
                rc  = gmul(rc, 8'h02);
            end
            w[i] = w[i-4] ^ tmp;
        end
        for (int r = 0; r < 11; r++) refRk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    endtask

    task automatic checkOutput(input string name, input logic [127:0] actual, input logic [127:0] expected);
        nCompared++;
        if (actual !== expected) begin
            nFailed++;
            $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
        end
    endtask

    // S-box memory: acks each request after a per-request delay drawn from [minDelay, maxDelay]
    initial begin
        int  cnt;
        int  curDelay;
        bit  waiting;
        sbox_ack = 1'b0; sbox_data = 8'h00; cnt = 0; curDelay = 0; waiting = 1'b0;
        forever begin
            @(negedge clk);
            sbox_ack = 1'b0;
            if (sbox_req && ackEnable) begin
                if (!waiting) begin
                    waiting  = 1'b1;
                    cnt      = 0;
                    curDelay = $urandom_range(maxDelay, minDelay);
                end
                if (cnt == curDelay) begin
                    sbox_ack  = 1'b1;
                    sbox_data = sboxTab[sbox_addr];
                    waiting   = 1'b0;
                end else begin
                    cnt++;
                end
            end else begin
                waiting = 1'b0;
            end
        end
    end

    // Handshake protocol watcher: address held while waiting, and a req-low gap after every ack
    always @(posedge clk) begin
        #1;
        if (monPrevReq && sbox_req && !sbox_ack && sbox_addr != monPrevAddr) addrViol++;
        if (monPrevReq && sbox_ack && sbox_req) gapViol++;
        monPrevReq  = sbox_req;
        monPrevAddr = sbox_addr;
    end

    task automatic readRk(input int sel, output logic [127:0] value);
        @(negedge clk);
        rk_sel = 4'(sel);
        @(negedge clk);
        value = rk_out;
    endtask

    // Pulses start with a new key, checks the LOAD-cycle clears and the old-value read of rk0
    task automatic applyStimulus(input string name, input logic [127:0] k, output int reqSeen);
        @(negedge clk);
        key    = k;
        start  = 1'b1;
        rk_sel = 4'd0;
        @(negedge clk);
        start = 1'b0;
        checkOutput({name, "_load_busy"}, 128'(busy), 128'(1));
        checkOutput({name, "_load_valid"}, 128'(rk_valid), 128'(0));
        checkOutput({name, "_load_err"}, 128'(err), 128'(0));
        @(negedge clk);
        checkOutput({name, "_rk0_old"}, rk_out, lastRk0);
        lastRk0 = k;
        reqSeen = sbox_req ? 1 : 0;
    endtask

    task automatic waitIdle(input string name, input int budget, input int restartAt,
                            input logic [127:0] restartKey, output int dones, output int reqCycles);
        bit ok;
        dones = 0; reqCycles = 0; ok = 1'b0;
        for (int c = 0; c < budget; c++) begin
            @(negedge clk);
            if (c == restartAt) begin
                start = 1'b1;
                key   = restartKey;
            end else begin
                start = 1'b0;
            end
            if (done) dones++;
            if (sbox_req) reqCycles++;
            if (!busy) begin
                ok = 1'b1;
                break;
            end
        end
        start = 1'b0;
        checkOutput({name, "_finished"}, 128'(ok), 128'(1));
    endtask

    task automatic checkSchedule(input string name);
        logic [127:0] v;
        for (int r = 0; r < 11; r++) begin
            readRk(r, v);
            checkOutput($sformatf("%s_rk%0d", name, r), v, refRk[r]);
        end
        checkOutput({name, "_valid"}, 128'(rk_valid), 128'(11'h7ff));
        checkOutput({name, "_err"}, 128'(err), 128'(0));
        checkOutput({name, "_busy"}, 128'(busy), 128'(0));
    endtask

    initial begin
        vec_t         vecs [4];
        logic [127:0] v;
        logic [127:0] rk;
        int           dones;
        int           reqA;
        int           reqB;
        bit           reached;

        vecs[0] = '{"a1_d1",   KEY_A1,   1, 1,  128'ha0fafe1788542cb123a339392a6c7605, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6};
        vecs[1] = '{"a1_rnd",  KEY_A1,   0, 20, 128'ha0fafe1788542cb123a339392a6c7605, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6};
        vecs[2] = '{"zero_d1", KEY_ZERO, 1, 1,  128'h62636363626363636263636362636363, 128'hb4ef5bcb3e92e21123e951cf6f8f188e};
        vecs[3] = '{"zero_d0", KEY_ZERO, 0, 3,  128'h62636363626363636263636362636363, 128'hb4ef5bcb3e92e21123e951cf6f8f188e};

        rst = 1'b1; start = 1'b0; key = '0; rk_sel = 4'd0;
        buildSbox();
        repeat (3) @(negedge clk);
        checkOutput("reset_busy", 128'(busy), 128'(0));
        checkOutput("reset_req", 128'(sbox_req), 128'(0));
        checkOutput("reset_valid", 128'(rk_valid), 128'(0));
        checkOutput("reset_rkout", rk_out, 128'(0));
        checkOutput("reset_done_err", 128'({done, err}), 128'(0));
        rst = 1'b0;

        // Known-answer vectors with fixed and random S-box latency
        foreach (vecs[n]) begin
            minDelay = vecs[n].minD;
            maxDelay = vecs[n].maxD;
            computeRef(vecs[n].key);
            applyStimulus(vecs[n].name, vecs[n].key, reqA);
            waitIdle(vecs[n].name, 3000, -1, '0, dones, reqB);
            checkOutput({vecs[n].name, "_done_pulses"}, 128'(dones), 128'(1));
            readRk(1, v);
            checkOutput({vecs[n].name, "_kat_rk1"}, v, vecs[n].rk1);
            readRk(10, v);
            checkOutput({vecs[n].name, "_kat_rk10"}, v, vecs[n].rk10);
            checkSchedule(vecs[n].name);
        end

        readRk(11, v);
        checkOutput("sel11_zero", v, 128'(0));
        readRk(15, v);
        checkOutput("sel15_zero", v, 128'(0));

        // Start pulsed again mid-expansion with another key is ignored
        minDelay = 0; maxDelay = 5;
        computeRef(KEY_A1);
        applyStimulus("restart", KEY_A1, reqA);
        waitIdle("restart", 3000, 60, 128'hdeadbeef0123456789abcdeffedcba98, dones, reqB);
        checkOutput("restart_done_pulses", 128'(dones), 128'(1));
        checkSchedule("restart");

        // Randomized keys against the reference model
        for (int t = 0; t < 3; t++) begin
            logic [127:0] rk128;
            rk128 = {$urandom, $urandom, $urandom, $urandom};
            minDelay = 0; maxDelay = 20;
            computeRef(rk128);
            applyStimulus($sformatf("rand%0d", t), rk128, reqA);
            waitIdle($sformatf("rand%0d", t), 3000, -1, '0, dones, reqB);
            checkOutput($sformatf("rand%0d_done_pulses", t), 128'(dones), 128'(1));
            checkSchedule($sformatf("rand%0d", t));
        end

        // S-box memory never answers: timeout after 64 request cycles
        ackEnable = 1'b0;
        applyStimulus("tmo", 128'h00112233445566778899aabbccddeeff, reqA);
        waitIdle("tmo", 500, -1, '0, dones, reqB);
        checkOutput("tmo_req_cycles", 128'(reqA + reqB), 128'(64));
        checkOutput("tmo_err", 128'(err), 128'(1));
        checkOutput("tmo_busy", 128'(busy), 128'(0));
        checkOutput("tmo_done", 128'(dones), 128'(0));
        checkOutput("tmo_valid", 128'(rk_valid), 128'(11'h001));
        repeat (4) @(negedge clk);
        checkOutput("tmo_err_sticky", 128'({err, done}), 128'(2'b10));
        ackEnable = 1'b1;

        // Asynchronous reset during round 5, then a clean rerun
        minDelay = 1; maxDelay = 1;
        computeRef(KEY_A1);
        applyStimulus("rstmid", KEY_A1, reqA);
        reached = 1'b0;
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            if (rk_valid[4]) begin
                reached = 1'b1;
                break;
            end
        end
        checkOutput("rstmid_reach_round5", 128'(reached), 128'(1));
        repeat (7) @(negedge clk);
        rst = 1'b1;
        #1;
        checkOutput("rstmid_req", 128'(sbox_req), 128'(0));
        checkOutput("rstmid_flags", 128'({busy, done, err}), 128'(0));
        checkOutput("rstmid_valid", 128'(rk_valid), 128'(0));
        checkOutput("rstmid_rkout_addr", {rk_out[119:0], sbox_addr}, 128'(0));
        @(negedge clk);
        rst = 1'b0;
        lastRk0 = '0;
        readRk(1, rk);
        checkOutput("rstmid_store_cleared", rk, 128'(0));
        applyStimulus("rerun", KEY_A1, reqA);
        waitIdle("rerun", 3000, -1, '0, dones, reqB);
        checkOutput("rerun_done_pulses", 128'(dones), 128'(1));
        checkSchedule("rerun");

        checkOutput("proto_addr_stable", 128'(addrViol), 128'(0));
        checkOutput("proto_req_gap", 128'(gapViol), 128'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nFailed);
        $finish;
    end

endmodule
